// File: rtl/pc_sequencer_pkg.sv
// Shared constants and redirect-kind encoding for the IF-stage PC sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_WIDTH      = 32;
    localparam int unsigned PC_INCR       = 4;
    localparam int unsigned PC_OFF_W      = 16;
    localparam int unsigned PC_SHIFT      = 2;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR = 32'h8000_0180;

    // Ordered by priority; RK_EXC is the only kind a pending entry defends against overwrite.
    typedef enum logic [1:0] {
        RK_NONE   = 2'd0,
        RK_BRANCH = 2'd1,
        RK_JUMP   = 2'd2,
        RK_EXC    = 2'd3
    } redirect_kind_e;

endpackage

// File: rtl/pc_branch_adder.sv
// Branch target: base + (sign-extended offset << SHIFT), modulo 2^WIDTH.
module pc_branch_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFF_W = 16,
    parameter int unsigned SHIFT = 2
) (
    input  logic [WIDTH-1:0] base_i,
    input  logic [OFF_W-1:0] offset_i,
    output logic [WIDTH-1:0] target_o
);

    logic [WIDTH-1:0] offset_ext;
    logic [WIDTH-1:0] offset_shl;

    // An offset wider than the PC simply truncates; bits above WIDTH vanish either way.
    if (OFF_W < WIDTH) begin : g_sext
        assign offset_ext = {{(WIDTH - OFF_W){offset_i[OFF_W-1]}}, offset_i};
    end else begin : g_trunc
        assign offset_ext = offset_i[WIDTH-1:0];
    end

    assign offset_shl = offset_ext << SHIFT;
    assign target_o   = base_i + offset_shl;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator: PC register, redirect priority mux and a one-entry pending-redirect slot.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned      WIDTH      = PC_WIDTH,
    parameter int unsigned      INCR       = PC_INCR,
    parameter int unsigned      OFF_W      = PC_OFF_W,
    parameter int unsigned      SHIFT      = PC_SHIFT,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_VECTOR)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_base,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_incr,
    output logic [WIDTH-1:0] branch_target,
    output logic             fetch_valid,
    output logic             redirect_pend
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             pend_q, pend_d;
    redirect_kind_e   pend_kind_q, pend_kind_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    redirect_kind_e   new_kind;
    logic [WIDTH-1:0] new_target;

    pc_branch_adder #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W),
        .SHIFT (SHIFT)
    ) u_branch_adder (
        .base_i   (branch_base),
        .offset_i (branch_offset),
        .target_o (branch_target)
    );

    assign pc_plus_incr = pc_q + WIDTH'(INCR);

    // Highest-priority redirect requested this cycle.
    always_comb begin
        new_kind   = RK_NONE;
        new_target = '0;
        if (exc_valid) begin
            new_kind   = RK_EXC;
            new_target = EXC_VECTOR;
        end else if (jump_valid) begin
            new_kind   = RK_JUMP;
            new_target = jump_target;
        end else if (branch_taken) begin
            new_kind   = RK_BRANCH;
            new_target = branch_target;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = 1'b1;
        pend_d        = pend_q;
        pend_kind_d   = pend_kind_q;
        pend_target_d = pend_target_q;
        if (!stall) begin
            if (new_kind != RK_NONE) begin
                pc_d          = new_target;
                fetch_valid_d = 1'b0;
                pend_d        = 1'b0;
                pend_kind_d   = RK_NONE;
            end else if (pend_q) begin
                pc_d          = pend_target_q;
                fetch_valid_d = 1'b0;
                pend_d        = 1'b0;
                pend_kind_d   = RK_NONE;
            end else begin
                pc_d = pc_plus_incr;
            end
        end else if (new_kind != RK_NONE) begin
            pend_d = 1'b1;
            // A latched exception is never displaced by a lower-priority redirect.
            if (!(pend_q && pend_kind_q == RK_EXC && new_kind != RK_EXC)) begin
                pend_kind_d   = new_kind;
                pend_target_d = new_target;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_ADDR;
            fetch_valid_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_kind_q   <= RK_NONE;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            pend_q        <= pend_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = fetch_valid_q;
    assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 32-bit default instance plus an 8-bit instance for wrap cases.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, stall, branch_taken, jump_valid, exc_valid;
    logic [31:0] branch_base, jump_target;
    logic [15:0] branch_offset;
    logic [31:0] pc, pc_plus_incr, branch_target;
    logic        fetch_valid, redirect_pend;

    logic        reset_b, stall_b, branch_taken_b, jump_valid_b, exc_valid_b;
    logic [7:0]  branch_base_b, jump_target_b;
    logic [3:0]  branch_offset_b;
    logic [7:0]  pc_b, pc_plus_incr_b, branch_target_b;
    logic        fetch_valid_b, redirect_pend_b;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .exc_valid     (exc_valid),
        .pc            (pc),
        .pc_plus_incr  (pc_plus_incr),
        .branch_target (branch_target),
        .fetch_valid   (fetch_valid),
        .redirect_pend (redirect_pend)
    );

    pc_sequencer #(
        .WIDTH      (8),
        .INCR       (4),
        .OFF_W      (4),
        .SHIFT      (2),
        .RESET_ADDR (8'hF8),
        .EXC_VECTOR (8'h80)
    ) dut_b (
        .clock         (clock),
        .reset         (reset_b),
        .stall         (stall_b),
        .branch_taken  (branch_taken_b),
        .branch_base   (branch_base_b),
        .branch_offset (branch_offset_b),
        .jump_valid    (jump_valid_b),
        .jump_target   (jump_target_b),
        .exc_valid     (exc_valid_b),
        .pc            (pc_b),
        .pc_plus_incr  (pc_plus_incr_b),
        .branch_target (branch_target_b),
        .fetch_valid   (fetch_valid_b),
        .redirect_pend (redirect_pend_b)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] base;
        logic [15:0] off;
        logic        jv;
        logic [31:0] jt;
        logic        exc;
        logic [31:0] exp_pc;
        logic        exp_fv;
        logic        exp_pend;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic stl, input logic br, input logic [31:0] base,
                       input logic [15:0] off, input logic jv, input logic [31:0] jt, input logic exc,
                       input logic [31:0] exp_pc, input logic exp_fv, input logic exp_pend);
        vec_t v;
        v.rst = rst; v.stall = stl; v.br = br; v.base = base; v.off = off;
        v.jv = jv; v.jt = jt; v.exc = exc;
        v.exp_pc = exp_pc; v.exp_fv = exp_fv; v.exp_pend = exp_pend;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump_valid = 1'b0; exc_valid = 1'b0;
        branch_base = '0; branch_offset = '0; jump_target = '0;
    endtask

    initial begin
        idle_a();
        reset_b = 1'b1; stall_b = 1'b0; branch_taken_b = 1'b0; jump_valid_b = 1'b0;
        exc_valid_b = 1'b0; branch_base_b = '0; branch_offset_b = '0; jump_target_b = '0;

        //   rst stl br base          off       jv jt            exc exp_pc        fv pend
        add(1, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h0,        0, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h4,        1, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h8,        1, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'hC,        1, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h10,       1, 0);
        add(0, 0, 0, 32'h0,        16'h0,    1, 32'h100,   0, 32'h100,      0, 0);
        add(0, 0, 1, 32'h104,      16'hFFFE, 0, 32'h0,     0, 32'hFC,       0, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h100,      1, 0);
        add(0, 1, 0, 32'h0,        16'h0,    1, 32'h400,   0, 32'h100,      1, 1);
        add(0, 1, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h100,      1, 1);
        add(0, 1, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h100,      1, 1);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h400,      0, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h404,      1, 0);
        add(0, 0, 1, 32'h104,      16'hFFFE, 1, 32'h400,   1, 32'h80000180, 0, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h80000184, 1, 0);
        add(0, 1, 0, 32'h0,        16'h0,    0, 32'h0,     1, 32'h80000184, 1, 1);
        add(0, 1, 0, 32'h0,        16'h0,    1, 32'h400,   0, 32'h80000184, 1, 1);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h80000180, 0, 0);
        add(0, 1, 1, 32'h200,      16'h0004, 0, 32'h0,     0, 32'h80000180, 1, 1);
        add(0, 1, 0, 32'h0,        16'h0,    1, 32'h500,   0, 32'h80000180, 1, 1);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h500,      0, 0);
        add(0, 1, 0, 32'h0,        16'h0,    1, 32'h700,   0, 32'h500,      1, 1);
        add(1, 1, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h0,        0, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h4,        1, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h8,        1, 0);
        add(0, 1, 0, 32'h0,        16'h0,    1, 32'h600,   0, 32'h8,        1, 1);
        add(0, 0, 1, 32'h1000,     16'h0001, 0, 32'h0,     0, 32'h1004,     0, 0);
        add(0, 0, 0, 32'h0,        16'h0,    0, 32'h0,     0, 32'h1008,     1, 0);

        foreach (vq[i]) begin
            @(negedge clock);
            reset = vq[i].rst; stall = vq[i].stall; branch_taken = vq[i].br;
            branch_base = vq[i].base; branch_offset = vq[i].off;
            jump_valid = vq[i].jv; jump_target = vq[i].jt; exc_valid = vq[i].exc;
            @(posedge clock);
            #1;
            check($sformatf("v%0d pc", i), pc, vq[i].exp_pc);
            check($sformatf("v%0d fetch_valid", i), 32'(fetch_valid), 32'(vq[i].exp_fv));
            check($sformatf("v%0d redirect_pend", i), 32'(redirect_pend), 32'(vq[i].exp_pend));
            check($sformatf("v%0d pc_plus_incr", i), pc_plus_incr, vq[i].exp_pc + 32'd4);
        end

        // Combinational branch target, with the PC frozen so nothing else moves.
        @(negedge clock);
        idle_a();
        stall = 1'b1;
        branch_base = 32'h104;      branch_offset = 16'hFFFE; #1;
        check("bt neg", branch_target, 32'h000000FC);
        branch_base = 32'h1000;     branch_offset = 16'h7FFF; #1;
        check("bt max pos", branch_target, 32'h00020FFC);
        branch_base = 32'h30000;    branch_offset = 16'h8000; #1;
        check("bt max neg", branch_target, 32'h00010000);
        branch_base = 32'hFFFFFFF0; branch_offset = 16'h0008; #1;
        check("bt wrap", branch_target, 32'h00000010);

        // 8-bit instance: sequential wrap, truncated exception vector, narrow offset.
        @(posedge clock); #1;
        check("b reset pc", 32'(pc_b), 32'h000000F8);
        check("b reset fv", 32'(fetch_valid_b), 32'h0);
        check("b ppi at F8", 32'(pc_plus_incr_b), 32'h000000FC);
        @(negedge clock); reset_b = 1'b0;
        @(posedge clock); #1;
        check("b pc FC", 32'(pc_b), 32'h000000FC);
        check("b ppi wrap", 32'(pc_plus_incr_b), 32'h00000000);
        @(posedge clock); #1;
        check("b pc wrap", 32'(pc_b), 32'h00000000);
        check("b fv", 32'(fetch_valid_b), 32'h1);
        @(negedge clock); exc_valid_b = 1'b1;
        @(posedge clock); #1;
        check("b exc pc", 32'(pc_b), 32'h00000080);
        check("b exc fv", 32'(fetch_valid_b), 32'h0);
        @(negedge clock); exc_valid_b = 1'b0; stall_b = 1'b1;
        branch_base_b = 8'h10; branch_offset_b = 4'hF; #1;
        check("b bt neg", 32'(branch_target_b), 32'h0000000C);
        branch_base_b = 8'hF0; branch_offset_b = 4'h7; #1;
        check("b bt wrap", 32'(branch_target_b), 32'h0000000C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
